// File: rtl/fetch_unit_if.sv
// Bundle between fetch_unit, its controller, the instruction ROM and the decoder.
// master is the fetch unit's view; slave is the environment's view.
interface fetch_unit_if;
   logic        start;
   logic        stall;
   logic        branch_en;
   logic [15:0] branch_target;
   logic        halt_req;
   logic [15:0] pc_out;
   logic [8:0]  rom_instr;
   logic [8:0]  ir_out;
   logic [15:0] ir_pc;
   logic        ir_valid;
   logic        halted;
   logic [15:0] fetch_count;

   modport master (
      input  start, stall, branch_en, branch_target, halt_req, rom_instr,
      output pc_out, ir_out, ir_pc, ir_valid, halted, fetch_count
   );

   modport slave (
      output start, stall, branch_en, branch_target, halt_req, rom_instr,
      input  pc_out, ir_out, ir_pc, ir_valid, halted, fetch_count
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: drives the ROM address, captures the returned word into the
// instruction register and sequences IDLE/RUN/HALT with branch, stall and halt control.
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'd0,
   parameter logic [15:0] PROG_LEN = 16'd121
) (
   input logic          clk,
   input logic          rst_n,
   fetch_unit_if.master bus
);

   typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [8:0]  ir_q, ir_d;
   logic [15:0] ir_pc_q, ir_pc_d;
   logic        ir_valid_q, ir_valid_d;
   logic [15:0] count_q, count_d;

   logic        past_end;
   logic [15:0] count_inc;

   assign past_end  = (pc_q >= PROG_LEN);
   assign count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         pc_q       <= RESET_PC;
         ir_q       <= 9'd0;
         ir_pc_q    <= 16'd0;
         ir_valid_q <= 1'b0;
         count_q    <= 16'd0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_pc_q    <= ir_pc_d;
         ir_valid_q <= ir_valid_d;
         count_q    <= count_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_pc_d    = ir_pc_q;
      ir_valid_d = ir_valid_q;
      count_d    = count_q;

      unique case (state_q)
         StIdle, StHalt: begin
            if (bus.start) begin
               state_d    = StRun;
               pc_d       = RESET_PC;
               ir_valid_d = 1'b0;
               count_d    = 16'd0;
            end
         end
         StRun: begin
            if (bus.halt_req) begin
               state_d    = StHalt;
               ir_valid_d = 1'b0;
            end else if (bus.start) begin
               pc_d       = RESET_PC;
               ir_valid_d = 1'b0;
               count_d    = 16'd0;
            end else if (bus.branch_en) begin
               // Redirect wins over stall; the word at the old PC is dropped.
               pc_d       = bus.branch_target;
               ir_valid_d = 1'b0;
            end else if (past_end) begin
               state_d    = StHalt;
               ir_valid_d = 1'b0;
            end else if (!bus.stall) begin
               ir_d       = bus.rom_instr;
               ir_pc_d    = pc_q;
               ir_valid_d = 1'b1;
               pc_d       = pc_q + 16'd1;
               count_d    = count_inc;
            end
         end
         default: begin
            state_d    = StIdle;
            ir_valid_d = 1'b0;
         end
      endcase
   end

   assign bus.pc_out      = pc_q;
   assign bus.ir_out      = ir_q;
   assign bus.ir_pc       = ir_pc_q;
   assign bus.ir_valid    = ir_valid_q;
   assign bus.halted      = (state_q == StHalt);
   assign bus.fetch_count = count_q;

   // A halted unit never presents a live instruction.
   a_halt_not_valid : assert property (
      @(posedge clk) disable iff (!rst_n) (state_q == StHalt) |-> !ir_valid_q
   );

   // IDLE is only reachable through reset, so the PC there is always the reset PC.
   a_idle_pc : assert property (
      @(posedge clk) disable iff (!rst_n) (state_q == StIdle) |-> (pc_q == RESET_PC)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (short and maximal program length) share stimulus and
// are checked each cycle against a rule-level model, plus hand-computed spot values.
module tb_fetch_unit;

   localparam logic [15:0] RST_PC = 16'd0;

   typedef struct packed {
      bit        run;
      bit        halt;
      bit [15:0] pc;
      bit [8:0]  ir;
      bit [15:0] ir_pc;
      bit        valid;
      bit [15:0] cnt;
   } model_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        stall = 1'b0;
   logic        branch_en = 1'b0;
   logic        halt_req = 1'b0;
   logic [15:0] branch_target = 16'd0;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en = 1'b0;

   model_t m0, m1;

   fetch_unit_if bus0 ();
   fetch_unit_if bus1 ();

   function automatic logic [8:0] rom_word(input logic [15:0] a);
      case (a)
         16'd0:   rom_word = 9'b000000000;
         16'd1:   rom_word = 9'b101111000;
         16'd2:   rom_word = 9'b010000000;
         16'd4:   rom_word = 9'b001000000;
         16'd5:   rom_word = 9'b101111110;
         16'd120: rom_word = 9'b110110000;
         default: rom_word = {a[3:0], a[8:4]} ^ 9'h1C3;
      endcase
   endfunction

   assign bus0.start         = start;
   assign bus0.stall         = stall;
   assign bus0.branch_en     = branch_en;
   assign bus0.branch_target = branch_target;
   assign bus0.halt_req      = halt_req;
   assign bus0.rom_instr     = rom_word(bus0.pc_out);

   assign bus1.start         = start;
   assign bus1.stall         = stall;
   assign bus1.branch_en     = branch_en;
   assign bus1.branch_target = branch_target;
   assign bus1.halt_req      = halt_req;
   assign bus1.rom_instr     = rom_word(bus1.pc_out);

   fetch_unit #(.RESET_PC(RST_PC), .PROG_LEN(16'd121)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   fetch_unit #(.RESET_PC(RST_PC), .PROG_LEN(16'hFFFF)) u_dut_long (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   always #5 clk = ~clk;

   function automatic model_t model_reset();
      model_t r;
      r    = '0;
      r.pc = RST_PC;
      return r;
   endfunction

   // One clock of the unit described as a priority list of rules.
   function automatic model_t model_step(input model_t s, input int unsigned plen);
      model_t n;
      n = s;
      if (!s.run) begin
         if (start) begin
            n.run = 1'b1; n.halt = 1'b0; n.pc = RST_PC; n.valid = 1'b0; n.cnt = 16'd0;
         end
      end else if (halt_req) begin
         n.run = 1'b0; n.halt = 1'b1; n.valid = 1'b0;
      end else if (start) begin
         n.pc = RST_PC; n.valid = 1'b0; n.cnt = 16'd0;
      end else if (branch_en) begin
         n.pc = branch_target; n.valid = 1'b0;
      end else if (int'(s.pc) >= int'(plen)) begin
         n.run = 1'b0; n.halt = 1'b1; n.valid = 1'b0;
      end else if (!stall) begin
         n.ir    = rom_word(s.pc);
         n.ir_pc = s.pc;
         n.valid = 1'b1;
         n.pc    = 16'((int'(s.pc) + 1) % 65536);
         n.cnt   = (s.cnt == 16'hFFFF) ? s.cnt : 16'(int'(s.cnt) + 1);
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m0 <= model_reset();
         m1 <= model_reset();
      end else begin
         m0 <= model_step(m0, 121);
         m1 <= model_step(m1, 65535);
      end
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m0 pc_out",      bus0.pc_out,      m0.pc);
         chk("m0 ir_out",      bus0.ir_out,      m0.ir);
         chk("m0 ir_pc",       bus0.ir_pc,       m0.ir_pc);
         chk("m0 ir_valid",    bus0.ir_valid,    m0.valid);
         chk("m0 halted",      bus0.halted,      m0.halt);
         chk("m0 fetch_count", bus0.fetch_count, m0.cnt);
         chk("m1 pc_out",      bus1.pc_out,      m1.pc);
         chk("m1 ir_out",      bus1.ir_out,      m1.ir);
         chk("m1 ir_pc",       bus1.ir_pc,       m1.ir_pc);
         chk("m1 ir_valid",    bus1.ir_valid,    m1.valid);
         chk("m1 halted",      bus1.halted,      m1.halt);
         chk("m1 fetch_count", bus1.fetch_count, m1.cnt);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, " pc0"},    bus0.pc_out,      RST_PC);
      chk({tag, " ir0"},    bus0.ir_out,      16'd0);
      chk({tag, " irpc0"},  bus0.ir_pc,       16'd0);
      chk({tag, " valid0"}, bus0.ir_valid,    16'd0);
      chk({tag, " halt0"},  bus0.halted,      16'd0);
      chk({tag, " cnt0"},   bus0.fetch_count, 16'd0);
      chk({tag, " pc1"},    bus1.pc_out,      RST_PC);
      chk({tag, " valid1"}, bus1.ir_valid,    16'd0);
      chk({tag, " cnt1"},   bus1.fetch_count, 16'd0);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1 cmp_en = 1'b1;
      tick();
      tick();
      chk_reset_values("reset");
      rst_n = 1'b1;
      tick();
      tick();
      chk("idle pc", bus0.pc_out, 16'd0);
      chk("idle valid", bus0.ir_valid, 16'd0);

      // Start and three unstalled fetches.
      start = 1'b1; tick(); start = 1'b0;
      chk("start pc", bus0.pc_out, 16'd0);
      chk("start cnt", bus0.fetch_count, 16'd0);
      tick();
      chk("f0 ir", bus0.ir_out, 16'(9'b000000000));
      chk("f0 irpc", bus0.ir_pc, 16'd0);
      tick();
      chk("f1 ir", bus0.ir_out, 16'(9'b101111000));
      chk("f1 irpc", bus0.ir_pc, 16'd1);
      tick();
      chk("f2 ir", bus0.ir_out, 16'(9'b010000000));
      chk("f2 irpc", bus0.ir_pc, 16'd2);
      chk("f2 cnt", bus0.fetch_count, 16'd3);

      // Stall two cycles at pc 5.
      tick(); tick();
      chk("pre-stall pc", bus0.pc_out, 16'd5);
      stall = 1'b1; tick(); tick(); stall = 1'b0;
      chk("stall pc", bus0.pc_out, 16'd5);
      chk("stall ir", bus0.ir_out, 16'(9'b001000000));
      chk("stall cnt", bus0.fetch_count, 16'd5);
      tick();
      chk("unstall ir", bus0.ir_out, 16'(9'b101111110));
      chk("unstall pc", bus0.pc_out, 16'd6);

      // Branch with stall at pc 10, then run off the end of the program.
      repeat (4) tick();
      chk("pre-branch pc", bus0.pc_out, 16'd10);
      branch_en = 1'b1; branch_target = 16'd120; stall = 1'b1;
      tick();
      branch_en = 1'b0; stall = 1'b0;
      chk("branch pc", bus0.pc_out, 16'd120);
      chk("branch valid", bus0.ir_valid, 16'd0);
      chk("branch irpc kept", bus0.ir_pc, 16'd9);
      tick();
      chk("b120 ir", bus0.ir_out, 16'(9'b110110000));
      chk("b120 irpc", bus0.ir_pc, 16'd120);
      tick();
      chk("end halted", bus0.halted, 16'd1);
      chk("end pc", bus0.pc_out, 16'd121);

      // Controls ignored while halted; long instance still runs and takes halt_req.
      branch_en = 1'b1; branch_target = 16'd50; halt_req = 1'b1; stall = 1'b1;
      tick();
      branch_en = 1'b0; halt_req = 1'b0; stall = 1'b0;
      chk("halt ignore pc", bus0.pc_out, 16'd121);
      chk("long halt pc", bus1.pc_out, 16'd122);
      chk("long halted", bus1.halted, 16'd1);

      // halt_req beats branch_en at pc 7, then restart.
      start = 1'b1; tick(); start = 1'b0;
      chk("restart halted", bus0.halted, 16'd0);
      repeat (7) tick();
      chk("pre-halt pc", bus0.pc_out, 16'd7);
      halt_req = 1'b1; branch_en = 1'b1; branch_target = 16'd99;
      tick();
      halt_req = 1'b0; branch_en = 1'b0;
      chk("hreq halted", bus0.halted, 16'd1);
      chk("hreq pc", bus0.pc_out, 16'd7);
      chk("hreq valid", bus0.ir_valid, 16'd0);
      tick();
      start = 1'b1; tick(); start = 1'b0;
      chk("restart2 pc", bus0.pc_out, 16'd0);
      chk("restart2 cnt", bus0.fetch_count, 16'd0);

      // Top of the address space with the maximal program length.
      branch_en = 1'b1; branch_target = 16'hFFFE; tick(); branch_en = 1'b0;
      tick();
      chk("top irpc", bus1.ir_pc, 16'hFFFE);
      chk("top pc", bus1.pc_out, 16'hFFFF);
      chk("short top halted", bus0.halted, 16'd1);
      tick();
      chk("top halted", bus1.halted, 16'd1);
      chk("top halt pc", bus1.pc_out, 16'hFFFF);

      // Asynchronous reset in the middle of a cycle while running.
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      #2 rst_n = 1'b0;
      #1 chk_reset_values("async");
      tick();
      rst_n = 1'b1;
      tick(); tick();
      chk("post-reset idle pc", bus0.pc_out, 16'd0);
      chk("post-reset idle valid", bus0.ir_valid, 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
